// File: rtl/proc_cmd_sequencer.sv
// Command sequencer for the 8-bit logic processor: queues LOADA/LOADB/EXEC/PRST
// requests and replays them as timed switch settings and button presses.
module proc_cmd_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 16,
  parameter int EXEC_WAIT   = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic [2:0] cmd_f,
  input  logic [1:0] cmd_r,
  output logic [7:0] Din,
  output logic [2:0] F,
  output logic [1:0] R,
  output logic       LoadA,
  output logic       LoadB,
  output logic       Execute,
  output logic       ProcReset,
  input  logic [7:0] Aval,
  input  logic [7:0] Bval,
  output logic       res_valid,
  output logic [7:0] res_a,
  output logic [7:0] res_b,
  output logic       busy
);

  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_HG > EXEC_WAIT) ? CNT_MAX_HG : EXEC_WAIT;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(EXEC_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_Q0   = (PTR_W + 1)'(0);
  localparam logic [PTR_W:0]   CNT_Q1   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_QMAX = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    OP_LOADA = 2'b00,
    OP_LOADB = 2'b01,
    OP_EXEC  = 2'b10,
    OP_PRST  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_PRESS   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_WAIT    = 3'd4,
    ST_CAPTURE = 3'd5
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] data;
    logic [2:0] f;
    logic [1:0] r;
  } cmd_t;

  cmd_t             fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_s;
  logic             pop_s;
  logic             ready_s;
  cmd_t             in_s;
  cmd_t             head_s;

  state_e           state_r;
  op_e              cur_op_r;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       din_r;
  logic [2:0]       f_r;
  logic [1:0]       r_r;
  logic             load_a_r;
  logic             load_b_r;
  logic             execute_r;
  logic             proc_reset_r;
  logic             res_valid_r;
  logic [7:0]       res_a_r;
  logic [7:0]       res_b_r;

  // Queue handshake and head-of-queue view.
  always_comb begin
    in_s.op   = op_e'(cmd_op);
    in_s.data = cmd_data;
    in_s.f    = cmd_f;
    in_s.r    = cmd_r;
    ready_s   = (count_r != CNT_QMAX);
    push_s    = cmd_valid && ready_s;
    pop_s     = (state_r == ST_IDLE) && (count_r != CNT_Q0);
    head_s    = fifo_mem_r[rd_ptr_r];
  end

  // Queue storage; validity is tracked by the pointers, so no reset is needed here.
  always_ff @(posedge Clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= in_s;
    end
  end

  // Queue pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_Q0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_Q1;
        2'b01:   count_r <= count_r - CNT_Q1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sequencing FSM: every counted state reloads the down-counter on entry and leaves at zero.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r      <= ST_IDLE;
      cur_op_r     <= OP_LOADA;
      cnt_r        <= CNT_ZERO;
      din_r        <= 8'h00;
      f_r          <= 3'b000;
      r_r          <= 2'b00;
      load_a_r     <= 1'b0;
      load_b_r     <= 1'b0;
      execute_r    <= 1'b0;
      proc_reset_r <= 1'b0;
      res_valid_r  <= 1'b0;
      res_a_r      <= 8'h00;
      res_b_r      <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            cur_op_r <= head_s.op;
            cnt_r    <= HOLD_LD;
            state_r  <= ST_SETUP;
            // Only the fields an op uses are driven; the rest keep their last setting.
            case (head_s.op)
              OP_LOADA, OP_LOADB: din_r <= head_s.data;
              OP_EXEC: begin
                f_r <= head_s.f;
                r_r <= head_s.r;
              end
              default: din_r <= din_r;
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (cnt_r == CNT_ZERO) begin
            cnt_r   <= HOLD_LD;
            state_r <= ST_PRESS;
            case (cur_op_r)
              OP_LOADA: load_a_r     <= 1'b1;
              OP_LOADB: load_b_r     <= 1'b1;
              OP_EXEC:  execute_r    <= 1'b1;
              default:  proc_reset_r <= 1'b1;
            endcase
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_PRESS: begin
          if (cnt_r == CNT_ZERO) begin
            load_a_r     <= 1'b0;
            load_b_r     <= 1'b0;
            execute_r    <= 1'b0;
            proc_reset_r <= 1'b0;
            cnt_r        <= GAP_LD;
            state_r      <= ST_RELEASE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (cnt_r == CNT_ZERO) begin
            if (cur_op_r == OP_EXEC) begin
              cnt_r   <= WAIT_LD;
              state_r <= ST_WAIT;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_WAIT: begin
          if (cnt_r == CNT_ZERO) begin
            res_a_r     <= Aval;
            res_b_r     <= Bval;
            res_valid_r <= 1'b1;
            state_r     <= ST_CAPTURE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_CAPTURE: begin
          res_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          load_a_r     <= 1'b0;
          load_b_r     <= 1'b0;
          execute_r    <= 1'b0;
          proc_reset_r <= 1'b0;
          res_valid_r  <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = ready_s;
  assign Din       = din_r;
  assign F         = f_r;
  assign R         = r_r;
  assign LoadA     = load_a_r;
  assign LoadB     = load_b_r;
  assign Execute   = execute_r;
  assign ProcReset = proc_reset_r;
  assign res_valid = res_valid_r;
  assign res_a     = res_a_r;
  assign res_b     = res_b_r;
  assign busy      = (state_r != ST_IDLE) || (count_r != CNT_Q0);

endmodule

// File: tb/tb_proc_cmd_sequencer.sv
// Bench for proc_cmd_sequencer: a small processor model on the pins plus a
// command-schedule reference model compared against the DUT every cycle.
module tb_proc_cmd_sequencer;

  localparam int H = 2;
  localparam int G = 2;
  localparam int W = 12;
  localparam int D = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic [2:0] cmd_f = 3'b000;
  logic [1:0] cmd_r = 2'b00;
  logic [7:0] Din;
  logic [2:0] F;
  logic [1:0] R;
  logic       LoadA, LoadB, Execute, ProcReset;
  logic [7:0] Aval, Bval;
  logic       res_valid;
  logic [7:0] res_a, res_b;
  logic       busy;

  proc_cmd_sequencer #(
    .FIFO_DEPTH(D), .HOLD_CYCLES(H), .GAP_CYCLES(G), .EXEC_WAIT(W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_f(cmd_f), .cmd_r(cmd_r),
    .Din(Din), .F(F), .R(R), .LoadA(LoadA), .LoadB(LoadB), .Execute(Execute),
    .ProcReset(ProcReset), .Aval(Aval), .Bval(Bval), .res_valid(res_valid),
    .res_a(res_a), .res_b(res_b), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Processor behaviour: result of F on A/B, then routed by R. Returns {A,B}.
  function automatic logic [15:0] proc_op(input logic [2:0] f, input logic [1:0] r,
                                          input logic [7:0] a, input logic [7:0] b);
    logic [7:0] y;
    case (f)
      3'b000:  y = a & b;
      3'b001:  y = a | b;
      3'b010:  y = a ^ b;
      3'b011:  y = 8'hFF;
      3'b100:  y = ~(a & b);
      3'b101:  y = ~(a | b);
      3'b110:  y = ~(a ^ b);
      default: y = 8'h00;
    endcase
    case (r)
      2'b00:   return {y, b};
      2'b01:   return {a, y};
      2'b10:   return {y, y};
      default: return {b, a};
    endcase
  endfunction

  // Processor model driven by the DUT's switch/button pins (acts on rising edges).
  logic [7:0] pa = 8'h00, pb = 8'h00;
  assign Aval = pa;
  assign Bval = pb;
  initial begin : proc_model
    logic pla, plb, pex, ppr;
    pla = 1'b0; plb = 1'b0; pex = 1'b0; ppr = 1'b0;
    forever begin
      @(negedge Clk);
      if (LoadA && !pla) pa = Din;
      if (LoadB && !plb) pb = Din;
      if (Execute && !pex) {pa, pb} = proc_op(F, R, pa, pb);
      if (ProcReset && !ppr) begin pa = 8'h00; pb = 8'h00; end
      pla = LoadA; plb = LoadB; pex = Execute; ppr = ProcReset;
    end
  end

  // Reference model: commands are scheduled from the timing rules, not from states.
  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [2:0] f;
    logic [1:0] r;
  } cmd_s;

  cmd_s       q[$];
  int         cyc = 0;
  int         next_pop_ok = 0, fsm_end = 0, press_lo = 0, press_hi = 0, cap = -1;
  logic [3:0] btn_type = 4'b0000, e_btn = 4'b0000;
  logic [7:0] e_din = 8'h00, e_a = 8'h00, e_b = 8'h00;
  logic [7:0] ra = 8'h00, rb = 8'h00, cap_a = 8'h00, cap_b = 8'h00;
  logic [2:0] e_f = 3'b000;
  logic [1:0] e_r = 2'b00;
  logic       e_rv = 1'b0, e_busy = 1'b0, e_ready = 1'b1, model_ok = 1'b0;

  initial begin : ref_model
    int   sz;
    cmd_s c;
    forever begin
      @(posedge Clk);
      if (!Reset) begin
        q.delete();
        next_pop_ok = 0; fsm_end = 0; press_lo = 0; press_hi = 0; cap = -1;
        e_din = 8'h00; e_f = 3'b000; e_r = 2'b00; e_btn = 4'b0000;
        e_rv = 1'b0; e_a = 8'h00; e_b = 8'h00; e_busy = 1'b0; e_ready = 1'b1;
        model_ok = 1'b1;
      end else begin
        sz = q.size();
        cyc++;
        if (cyc >= next_pop_ok && sz > 0) begin
          c = q.pop_front();
          case (c.op)
            2'b00: begin e_din = c.data; ra = c.data; end
            2'b01: begin e_din = c.data; rb = c.data; end
            2'b10: begin e_f = c.f; e_r = c.r; {ra, rb} = proc_op(c.f, c.r, ra, rb); end
            default: begin ra = 8'h00; rb = 8'h00; end
          endcase
          btn_type = 4'b0001 << c.op;
          press_lo = cyc + H;
          press_hi = cyc + 2 * H;
          if (c.op == 2'b10) begin
            cap = cyc + 2 * H + G + W;
            cap_a = ra; cap_b = rb;
            fsm_end = cap + 1;
          end else begin
            fsm_end = cyc + 2 * H + G;
          end
          next_pop_ok = fsm_end + 1;
        end
        if (cmd_valid && sz != D) q.push_back('{cmd_op, cmd_data, cmd_f, cmd_r});
        e_btn = (cyc >= press_lo && cyc < press_hi) ? btn_type : 4'b0000;
        e_rv = (cyc == cap);
        if (e_rv) begin e_a = cap_a; e_b = cap_b; end
        e_busy = (cyc < fsm_end) || (q.size() != 0);
        e_ready = (q.size() != D);
      end
    end
  end

  // Per-cycle comparison of every output against the reference model.
  initial begin : compare
    forever begin
      @(negedge Clk);
      if (Reset && model_ok) begin
        check("cmd_ready", cmd_ready, e_ready);
        check("busy", busy, e_busy);
        check("Din", Din, e_din);
        check("F", F, e_f);
        check("R", R, e_r);
        check("buttons", {ProcReset, Execute, LoadB, LoadA}, e_btn);
        check("res_valid", res_valid, e_rv);
        check("res_a", res_a, e_a);
        check("res_b", res_b, e_b);
      end
    end
  end

  task automatic after_edges(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Offer one command, holding cmd_valid until accepted; call just after a rising edge.
  task automatic send(input logic [1:0] op, input logic [7:0] d,
                      input logic [2:0] f, input logic [1:0] r);
    int guard;
    guard = 0;
    cmd_op = op; cmd_data = d; cmd_f = f; cmd_r = r; cmd_valid = 1'b1;
    while (!cmd_ready && guard < 500) begin
      after_edges(1);
      guard++;
    end
    if (guard >= 500) begin
      tests++; fails++;
      $display("FAIL send_timeout: cmd_ready stayed 0 for %0d cycles, expected 1", guard);
    end
    after_edges(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output logic [7:0] a, output logic [7:0] b);
    int n;
    n = 0;
    while (!res_valid && n < 300) begin
      after_edges(1);
      n++;
    end
    if (!res_valid) begin
      tests++; fails++;
      $display("FAIL res_timeout: res_valid 0 after %0d cycles, expected 1", n);
    end
    a = res_a;
    b = res_b;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    after_edges(1);
    while (busy && n < budget) begin
      after_edges(1);
      n++;
    end
    if (busy) begin
      tests++; fails++;
      $display("FAIL idle_timeout: busy 1 after %0d cycles, expected 0", n);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    logic [7:0] a, b;
    int n;
    after_edges(3);
    Reset = 1'b1;
    after_edges(2);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_din", Din, 8'h00);

    // Single LOADA: Din at k+1, LoadA high from edge k+3 until edge k+5.
    send(2'b00, 8'h33, 3'b000, 2'b00);
    after_edges(1);
    check("loada_din", Din, 8'h33);
    check("loada_early", LoadA, 0);
    after_edges(2);
    check("loada_k3", LoadA, 1);
    after_edges(1);
    check("loada_k4", LoadA, 1);
    after_edges(1);
    check("loada_k5", LoadA, 0);
    after_edges(4);
    check("loada_idle", busy, 0);

    // Back-to-back LOADA/LOADB/EXEC: AND routed to A gives A=11, B=55.
    send(2'b00, 8'h33, 3'b000, 2'b00);
    send(2'b01, 8'h55, 3'b000, 2'b00);
    send(2'b10, 8'h00, 3'b000, 2'b00);
    wait_res(a, b);
    check("exec_res_a", a, 8'h11);
    check("exec_res_b", b, 8'h55);
    wait_idle(200);

    // Six commands held back to back: queue fills, ready drops, none lost.
    for (int i = 0; i < 6; i++)
      send(2'($urandom_range(0, 2)), 8'($urandom), 3'($urandom), 2'($urandom));
    wait_idle(500);

    // PRST between two EXECs; second result captured independently.
    send(2'b00, 8'h0F, 3'b000, 2'b00);
    send(2'b01, 8'hF0, 3'b000, 2'b00);
    send(2'b10, 8'h00, 3'b001, 2'b00);
    send(2'b11, 8'h00, 3'b000, 2'b00);
    send(2'b10, 8'h00, 3'b011, 2'b01);
    wait_res(a, b);
    check("prst_res1_a", a, 8'hFF);
    check("prst_res1_b", b, 8'hF0);
    after_edges(1);
    wait_res(a, b);
    check("prst_res2_a", a, 8'h00);
    check("prst_res2_b", b, 8'hFF);
    check("prst_f", F, 3'b011);
    check("prst_r", R, 2'b01);
    wait_idle(200);

    // Reset asserted while Execute is held, with two commands still queued.
    send(2'b10, 8'h00, 3'b010, 2'b00);
    send(2'b00, 8'hAA, 3'b000, 2'b00);
    send(2'b01, 8'hBB, 3'b000, 2'b00);
    n = 0;
    while (!Execute && n < 100) begin
      after_edges(1);
      n++;
    end
    check("midrst_exec_seen", Execute, 1);
    @(negedge Clk);
    #1 Reset = 1'b0;
    #1;
    check("midrst_exec_drop", Execute, 0);
    after_edges(2);
    Reset = 1'b1;
    after_edges(1);
    check("midrst_busy", busy, 0);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_din", Din, 8'h00);
    after_edges(40);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_op    = 2'($urandom);
      cmd_data  = 8'($urandom);
      cmd_f     = 3'($urandom);
      cmd_r     = 2'($urandom);
      after_edges(1);
    end
    cmd_valid = 1'b0;
    wait_idle(1000);
    after_edges(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
